// File: rtl/i2c_bus_acq_pkg.sv
// i2c_bus_acq_pkg: state and error encodings shared by the bus-acquire controller
package i2c_bus_acq_pkg;
  typedef enum logic [2:0] {IDLE, WAIT_BUS, BUF_WAIT, OWNED, RELEASING} state_e;
  typedef enum logic [1:0] {ERR_NONE, ERR_TIMEOUT, ERR_ARB_LOST, ERR_BUS_ERR} err_e;
endpackage

// File: rtl/i2c_bus_acquire_ctrl_if.sv
// i2c_bus_acquire_ctrl_if: transfer-engine / line-monitor signals of the bus-acquire controller
interface i2c_bus_acquire_ctrl_if #(parameter int CNT_W = 16);
  logic core_en, acq_req, rel_req, bus_busy, start_detected, stop_detected, arb_lost;
  logic [CNT_W-1:0] tbuf_cycles, timeout_cycles;
  logic detector_en, acq_grant, bus_owned, rel_done, acq_fail;
  logic [1:0] err_code;
  modport master(
    output core_en, acq_req, rel_req, bus_busy, start_detected, stop_detected, arb_lost,
           tbuf_cycles, timeout_cycles,
    input  detector_en, acq_grant, bus_owned, rel_done, acq_fail, err_code
  );
  modport slave(
    input  core_en, acq_req, rel_req, bus_busy, start_detected, stop_detected, arb_lost,
           tbuf_cycles, timeout_cycles,
    output detector_en, acq_grant, bus_owned, rel_done, acq_fail, err_code
  );
endinterface

// File: rtl/bus_acq_timer.sv
// bus_acq_timer: saturating cycle counter with sync clear and equality compare
module bus_acq_timer #(parameter int CNT_W = 16) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] cmp,
  output logic             eq
);
  logic [CNT_W-1:0] cnt, cnt_d;
  assign cnt_d = clr ? '0 : (inc && !(&cnt)) ? cnt + 1'b1 : cnt;
  assign eq = cnt == cmp;
  dff #(.W(CNT_W)) u_cnt (.clk(clk), .reset(reset), .d(cnt_d), .q(cnt));
endmodule

// File: rtl/dff.sv
// dff: W-bit register with synchronous active-high clear
module dff #(parameter int W = 1) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk) q <= reset ? '0 : d;
endmodule

// File: rtl/i2c_bus_acquire_ctrl.sv
// i2c_bus_acquire_ctrl: grants the I2C bus after a tBUF free window, tracks release and errors
module i2c_bus_acquire_ctrl
  import i2c_bus_acq_pkg::*;
#(parameter int CNT_W = 16) (
  input logic clk,
  input logic reset,
  i2c_bus_acquire_ctrl_if.slave bus
);
  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_WAIT = WAIT_BUS;
  localparam logic [2:0] S_BUF  = BUF_WAIT;
  localparam logic [2:0] S_OWN  = OWNED;
  localparam logic [2:0] S_REL  = RELEASING;
  logic [2:0] st, nxt;
  logic [1:0] err_n;
  logic clr, inc, eq, tmo, done_n, fail_n;
  logic [CNT_W-1:0] cmp;
  // one counter serves both the tBUF window and the busy/release timeout
  assign cmp = st == S_BUF ? bus.tbuf_cycles : bus.timeout_cycles;
  assign tmo = eq && bus.timeout_cycles != '0;
  bus_acq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .clr(clr), .inc(inc), .cmp(cmp), .eq(eq)
  );
  always_comb begin
    nxt = st;
    err_n = bus.err_code;
    clr = 1'b0;
    inc = 1'b0;
    done_n = 1'b0;
    fail_n = 1'b0;
    if (!bus.core_en) nxt = S_IDLE;
    else
      case (st)
        S_IDLE: if (bus.acq_req) begin nxt = S_WAIT; clr = 1'b1; err_n = ERR_NONE; end
        S_WAIT:
          if (!bus.bus_busy) begin nxt = S_BUF; clr = 1'b1; end
          else if (tmo) begin nxt = S_IDLE; fail_n = 1'b1; err_n = ERR_TIMEOUT; end
          else inc = 1'b1;
        S_BUF:
          if (bus.bus_busy || bus.start_detected) begin nxt = S_WAIT; clr = 1'b1; end
          else if (eq) nxt = S_OWN;
          else inc = 1'b1;
        S_OWN:
          if (bus.arb_lost) begin nxt = S_IDLE; fail_n = 1'b1; err_n = ERR_ARB_LOST; end
          else if (bus.stop_detected) begin nxt = S_IDLE; fail_n = 1'b1; err_n = ERR_BUS_ERR; end
          else if (bus.rel_req) begin nxt = S_REL; clr = 1'b1; end
        S_REL:
          if (bus.stop_detected) begin nxt = S_IDLE; done_n = 1'b1; end
          else if (tmo) begin nxt = S_IDLE; fail_n = 1'b1; err_n = ERR_TIMEOUT; end
          else inc = 1'b1;
        default: nxt = S_IDLE;
      endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      st <= S_IDLE;
      bus.detector_en <= 1'b0;
      bus.acq_grant <= 1'b0;
      bus.bus_owned <= 1'b0;
      bus.rel_done <= 1'b0;
      bus.acq_fail <= 1'b0;
      bus.err_code <= ERR_NONE;
    end else begin
      st <= nxt;
      bus.detector_en <= bus.core_en;
      bus.acq_grant <= st == S_BUF && nxt == S_OWN;
      bus.bus_owned <= nxt == S_OWN || nxt == S_REL;
      bus.rel_done <= done_n;
      bus.acq_fail <= fail_n;
      bus.err_code <= err_n;
    end
endmodule

// File: tb/tb_i2c_bus_acquire_ctrl.sv
// tb_i2c_bus_acquire_ctrl: directed and random stimulus checked against a cycle-level behavioural model
module tb_i2c_bus_acquire_ctrl;
  localparam int W = 8;
  localparam int MAXC = (1 << W) - 1;
  logic clk = 1'b0;
  logic reset;
  int checks = 0, failures = 0, cyc = 0, n, r;
  int ph, age, m_err;
  bit m_det, m_grant, m_own, m_done, m_fail;
  always #5 clk = ~clk;
  i2c_bus_acquire_ctrl_if #(.CNT_W(W)) bus();
  i2c_bus_acquire_ctrl #(.CNT_W(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask
  // phases: 0 idle, 1 waiting for free bus, 2 free window, 3 owned, 4 releasing
  task automatic model_step();
    int tmo;
    m_grant = 0; m_done = 0; m_fail = 0;
    if (reset) begin
      ph = 0; age = 0; m_err = 0; m_det = 0; m_own = 0;
      return;
    end
    m_det = bus.core_en;
    tmo = int'(bus.timeout_cycles);
    if (!bus.core_en) ph = 0;
    else if (ph == 0) begin
      if (bus.acq_req) begin ph = 1; age = 0; m_err = 0; end
    end else if (ph == 1) begin
      if (!bus.bus_busy) begin ph = 2; age = 0; end
      else if (tmo != 0 && age == tmo) begin ph = 0; m_fail = 1; m_err = 1; end
      else age = age < MAXC ? age + 1 : MAXC;
    end else if (ph == 2) begin
      if (bus.bus_busy || bus.start_detected) begin ph = 1; age = 0; end
      else if (age == int'(bus.tbuf_cycles)) begin ph = 3; m_grant = 1; end
      else age = age < MAXC ? age + 1 : MAXC;
    end else if (ph == 3) begin
      if (bus.arb_lost) begin ph = 0; m_fail = 1; m_err = 2; end
      else if (bus.stop_detected) begin ph = 0; m_fail = 1; m_err = 3; end
      else if (bus.rel_req) begin ph = 4; age = 0; end
    end else begin
      if (bus.stop_detected) begin ph = 0; m_done = 1; end
      else if (tmo != 0 && age == tmo) begin ph = 0; m_fail = 1; m_err = 1; end
      else age = age < MAXC ? age + 1 : MAXC;
    end
    m_own = ph == 3 || ph == 4;
  endtask
  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("detector_en", bus.detector_en, m_det);
    chk("acq_grant", bus.acq_grant, m_grant);
    chk("bus_owned", bus.bus_owned, m_own);
    chk("rel_done", bus.rel_done, m_done);
    chk("acq_fail", bus.acq_fail, m_fail);
    chk("err_code", bus.err_code, m_err);
  endtask
  task automatic quiet();
    bus.core_en = 1; bus.acq_req = 0; bus.rel_req = 0; bus.bus_busy = 0;
    bus.start_detected = 0; bus.stop_detected = 0; bus.arb_lost = 0;
  endtask
  task automatic acquire();
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    for (int i = 0; i < 300 && !bus.bus_owned; i++) step();
    chk("acquire", bus.bus_owned, 1);
  endtask
  initial begin
    quiet();
    bus.tbuf_cycles = 0;
    bus.timeout_cycles = 0;
    reset = 1;
    step();
    step();
    chk("rst_owned", bus.bus_owned, 0);
    chk("rst_det", bus.detector_en, 0);
    chk("rst_err", bus.err_code, 0);
    reset = 0;
    step();
    bus.tbuf_cycles = 5;
    n = cyc;
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    while (!bus.acq_grant && cyc - n < 100) step();
    chk("grant_lat", cyc - n, 8);
    chk("grant_owned", bus.bus_owned, 1);
    chk("grant_err", bus.err_code, 0);
    bus.rel_req = 1;
    step();
    bus.rel_req = 0;
    bus.stop_detected = 1;
    step();
    bus.stop_detected = 0;
    chk("rel_quick", bus.rel_done, 1);
    bus.bus_busy = 1;
    bus.timeout_cycles = 20;
    n = cyc;
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    while (!bus.acq_fail && cyc - n < 100) step();
    chk("tmo_lat", cyc - n, 22);
    chk("tmo_err", bus.err_code, 1);
    chk("tmo_owned", bus.bus_owned, 0);
    bus.bus_busy = 0;
    bus.timeout_cycles = 0;
    bus.tbuf_cycles = 10;
    n = cyc;
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    repeat (5) step();
    bus.bus_busy = 1;
    step();
    bus.bus_busy = 0;
    while (!bus.acq_grant && cyc - n < 100) step();
    chk("tbuf_restart", cyc - n, 19);
    bus.arb_lost = 1;
    bus.rel_req = 1;
    step();
    quiet();
    chk("arb_fail", bus.acq_fail, 1);
    chk("arb_err", bus.err_code, 2);
    chk("arb_nodone", bus.rel_done, 0);
    bus.tbuf_cycles = 0;
    acquire();
    bus.rel_req = 1;
    step();
    bus.rel_req = 0;
    repeat (6) step();
    bus.stop_detected = 1;
    step();
    bus.stop_detected = 0;
    chk("rel_done", bus.rel_done, 1);
    chk("rel_owned", bus.bus_owned, 0);
    bus.timeout_cycles = 3;
    acquire();
    r = cyc;
    bus.rel_req = 1;
    step();
    bus.rel_req = 0;
    while (!bus.acq_fail && cyc - r < 50) step();
    chk("rel_tmo_lat", cyc - r, 5);
    chk("rel_tmo_err", bus.err_code, 1);
    bus.timeout_cycles = 0;
    acquire();
    bus.core_en = 0;
    step();
    chk("dis_owned", bus.bus_owned, 0);
    chk("dis_fail", bus.acq_fail, 0);
    chk("dis_det", bus.detector_en, 0);
    bus.core_en = 1;
    step();
    chk("en_det", bus.detector_en, 1);
    bus.tbuf_cycles = 10;
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    repeat (3) step();
    reset = 1;
    step();
    reset = 0;
    chk("rstbuf_owned", bus.bus_owned, 0);
    chk("rstbuf_fail", bus.acq_fail, 0);
    step();
    bus.bus_busy = 1;
    bus.acq_req = 1;
    step();
    bus.acq_req = 0;
    repeat (300) step();
    bus.timeout_cycles = 8'(MAXC);
    step();
    chk("sat_tmo", bus.acq_fail, 1);
    bus.timeout_cycles = 0;
    quiet();
    for (int i = 0; i < 4000; i++) begin
      reset = $urandom_range(0, 199) == 0;
      bus.core_en = $urandom_range(0, 39) != 0;
      bus.acq_req = $urandom_range(0, 4) == 0;
      bus.rel_req = $urandom_range(0, 9) == 0;
      if ($urandom_range(0, 7) == 0) bus.bus_busy = ~bus.bus_busy;
      bus.start_detected = $urandom_range(0, 29) == 0;
      bus.stop_detected = $urandom_range(0, 19) == 0;
      bus.arb_lost = $urandom_range(0, 29) == 0;
      if ($urandom_range(0, 49) == 0) bus.tbuf_cycles = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 49) == 0)
        bus.timeout_cycles = $urandom_range(0, 3) == 0 ? 8'd0 : 8'($urandom_range(1, 20));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/i2c_bus_acquire_ctrl.md
# i2c_bus_acquire_ctrl

Bus-access controller for the APB I2C master. It sits between the transfer engine and the bus-busy detector. It enables the detector and accepts acquire/release requests from the transfer engine. It grants the bus only after the line has stayed free for a programmed bus-free time (tBUF), and it reports timeout, arbitration-loss and unexpected-STOP errors.

## Interface
Parameters:
- CNT_W, 16, width of the shared wait/tBUF/timeout counter and of the cycle-count config inputs

Ports:
- clk  input  1  system clock
- reset  input  1  reset; synchronous, active-high
- core_en  input  1  master enable (from control register)
- acq_req  input  1  transfer engine requests bus ownership (sampled in IDLE only)
- rel_req  input  1  transfer engine has issued STOP and releases the bus
- bus_busy  input  1  level from bus-busy detector
- start_detected  input  1  1-cycle START pulse from line monitor
- stop_detected  input  1  1-cycle STOP pulse from line monitor
- arb_lost  input  1  arbitration-lost pulse from SDA compare logic
- tbuf_cycles  input  CNT_W  required free-bus hold-off in clk cycles
- timeout_cycles  input  CNT_W  busy-wait / release timeout in clk cycles; 0 disables the timeout
- detector_en  output  1  flop enable for the bus-busy detector
- acq_grant  output  1  1-cycle pulse; ownership granted
- bus_owned  output  1  level; high while this master owns the bus
- rel_done  output  1  1-cycle pulse; release completed
- acq_fail  output  1  1-cycle pulse; acquisition or ownership aborted with error
- err_code  output  2  last error: NONE=0, TIMEOUT=1, ARB_LOST=2, BUS_ERR=3

## Operation
- Reset: state IDLE, counter 0. detector_en, acq_grant, bus_owned, rel_done and acq_fail are 0. err_code = NONE.
- detector_en: registered copy of core_en, so one cycle of latency.
- States:
  - IDLE → WAIT_BUS when acq_req & core_en. err_code clears to NONE and the counter loads 0. acq_req in any other state is ignored.
  - WAIT_BUS: counter increments each cycle. Goes to BUF_WAIT (counter loads 0) when bus_busy = 0. If timeout_cycles ≠ 0 and counter == timeout_cycles, goes to IDLE with acq_fail and err = TIMEOUT.
  - BUF_WAIT: if bus_busy = 1 or start_detected, goes back to WAIT_BUS with counter 0, and the timeout restarts. Else, if counter == tbuf_cycles, goes to OWNED. Else the counter increments.
  - OWNED: arb_lost goes to IDLE with err ARB_LOST. Else stop_detected goes to IDLE with err BUS_ERR. Else rel_req goes to RELEASING with counter 0.
  - RELEASING: stop_detected goes to IDLE with rel_done. The timeout applies as in WAIT_BUS (err TIMEOUT).
- Priority within a cycle: core_en = 0 beats arb_lost, which beats stop_detected, which beats rel_req. start_detected beats the tBUF compare.
- core_en = 0 in any state: IDLE next cycle, bus_owned drops, no pulses, err_code unchanged.
- acq_grant is asserted in the first OWNED cycle. bus_owned is high in OWNED and RELEASING.
- acq_fail and rel_done are asserted in the first IDLE cycle after the causing event.
- err_code is registered and holds until the next accepted acq_req.
- Counter saturates at all-ones and never wraps; this matters when timeout_cycles = 0.

## Timing
- Grant latency with the bus free: acq_req sampled at cycle N gives acq_grant at N+3+tbuf_cycles. With tbuf_cycles = 0 the grant is at N+3.
- Timeout: acq_fail occurs timeout_cycles+1 cycles after entering WAIT_BUS.
- All outputs are registered; no combinational input-to-output paths.
- Synchronous reset mid-operation: next cycle all outputs and state match reset values; no rel_done or acq_fail pulse.

## Structure
- Package i2c_bus_acq_pkg holds:
  - state enum: IDLE, WAIT_BUS, BUF_WAIT, OWNED, RELEASING
  - err_code enum and its 2-bit encoding
- Sub-module bus_acq_timer: CNT_W-bit counter with synchronous clear, increment enable, saturation and equality compare. Its flops use the team's dff cell.

## Test plan
- Bus free, tbuf_cycles = 5: acq_req at cycle 10 → acq_grant at cycle 18, bus_owned high, err_code NONE.
- Bus busy, timeout_cycles = 20, bus_busy never drops → acq_fail plus err_code TIMEOUT, 21 cycles after WAIT_BUS entry; bus_owned stays 0.
- tbuf_cycles = 10, bus_busy pulses high for 1 cycle 4 cycles into BUF_WAIT → no grant until a fresh 10-cycle free window completes.
- OWNED, arb_lost and rel_req in the same cycle → acq_fail, err_code ARB_LOST, no rel_done.
- OWNED, rel_req, then stop_detected 7 cycles later → rel_done the next cycle, bus_owned 0; timeout_cycles = 3 instead → acq_fail TIMEOUT.
- core_en drops in OWNED, and separately reset asserts in BUF_WAIT → IDLE next cycle with no pulses; detector_en falls one cycle after core_en.
